// File: rtl/rv_mem_arbiter.sv
// Two-requester memory port arbiter: fetch vs. data, data-first with
// bounded fetch starvation and a response timeout that completes with error.
module rv_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_insn_req,
  input  logic [31:0] i_insn_addr,
  output logic        o_insn_ack,
  output logic        o_insn_rvalid,
  output logic [31:0] o_insn_rdata,
  output logic        o_insn_err,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_wsel,
  output logic        o_data_ack,
  output logic        o_data_rvalid,
  output logic [31:0] o_data_rdata,
  output logic        o_data_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wsel,
  input  logic        i_mem_ack,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TEN = (TIMEOUT_CYCLES != 0);
  localparam logic [3:0] SMAX = 4'(MAX_DATA_STREAK);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [3:0]    streak_q, streak_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wsel_q, wsel_d;

  logic          irv_q, irv_d, ierr_q, ierr_d;
  logic          drv_q, drv_d, derr_q, derr_d;
  logic [31:0]   ird_q, ird_d, drd_q, drd_d;

  logic grant_d, grant_i, cmpl, tmo;
  logic [31:0] rsp_data;

  assign grant_d = (state_q == S_IDLE) && i_data_req &&
                   !(i_insn_req && (streak_q == SMAX));
  assign grant_i = (state_q == S_IDLE) && i_insn_req && !grant_d;

  // Stores finish on ack; loads and fetches need read data.
  assign cmpl = ((state_q == S_ISSUE) && i_mem_ack && (we_q || i_mem_rvalid)) ||
                ((state_q == S_WAIT) && i_mem_rvalid);
  assign tmo  = TEN && (state_q != S_IDLE) && (timer_q == TMAX) && !cmpl;
  assign rsp_data = (tmo || we_q) ? 32'h0 : i_mem_rdata;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    timer_d  = timer_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wsel_d   = wsel_q;
    irv_d    = 1'b0;
    ierr_d   = 1'b0;
    ird_d    = ird_q;
    drv_d    = 1'b0;
    derr_d   = 1'b0;
    drd_d    = drd_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d  = 1'b1;
          we_d     = i_data_we;
          addr_d   = i_data_addr;
          wdata_d  = i_data_wdata;
          wsel_d   = i_data_wsel;
          if (!i_insn_req)
            streak_d = 4'd0;
          else if (streak_q != SMAX)
            streak_d = streak_q + 4'd1;
        end else if (grant_i) begin
          owner_d  = 1'b0;
          we_d     = 1'b0;
          addr_d   = i_insn_addr;
          wdata_d  = 32'h0;
          wsel_d   = 4'b1111;
          streak_d = 4'd0;
        end
        if (grant_d || grant_i) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          timer_d = '0;
        end
      end
      S_ISSUE, S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if ((state_q == S_ISSUE) && i_mem_ack) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
        if (cmpl || tmo) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          if (owner_q) begin
            drv_d  = 1'b1;
            derr_d = tmo;
            drd_d  = rsp_data;
          end else begin
            irv_d  = 1'b1;
            ierr_d = tmo;
            ird_d  = rsp_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= 4'd0;
      timer_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wsel_q   <= 4'h0;
      irv_q    <= 1'b0;
      ierr_q   <= 1'b0;
      ird_q    <= 32'h0;
      drv_q    <= 1'b0;
      derr_q   <= 1'b0;
      drd_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      timer_q  <= timer_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wsel_q   <= wsel_d;
      irv_q    <= irv_d;
      ierr_q   <= ierr_d;
      ird_q    <= ird_d;
      drv_q    <= drv_d;
      derr_q   <= derr_d;
      drd_q    <= drd_d;
    end
  end

  // Acks stay quiet while reset is held even if requests are present.
  assign o_insn_ack    = grant_i && i_reset_n;
  assign o_data_ack    = grant_d && i_reset_n;
  assign o_insn_rvalid = irv_q;
  assign o_insn_rdata  = ird_q;
  assign o_insn_err    = ierr_q;
  assign o_data_rvalid = drv_q;
  assign o_data_rdata  = drd_q;
  assign o_data_err    = derr_q;
  assign o_mem_req     = req_q;
  assign o_mem_we      = we_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wdata   = wdata_q;
  assign o_mem_wsel    = wsel_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_rv_mem_arbiter;

  logic        i_clk, i_reset_n;
  logic        i_insn_req;
  logic [31:0] i_insn_addr;
  logic        o_insn_ack, o_insn_rvalid, o_insn_err;
  logic [31:0] o_insn_rdata;
  logic        i_data_req, i_data_we;
  logic [31:0] i_data_addr, i_data_wdata;
  logic [3:0]  i_data_wsel;
  logic        o_data_ack, o_data_rvalid, o_data_err;
  logic [31:0] o_data_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wsel;
  logic        i_mem_ack, i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_insn = 32'h0;
  logic [31:0] last_data = 32'h0;

  rv_mem_arbiter #(.TIMEOUT_CYCLES(8), .MAX_DATA_STREAK(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_insn_req(i_insn_req), .i_insn_addr(i_insn_addr),
    .o_insn_ack(o_insn_ack), .o_insn_rvalid(o_insn_rvalid),
    .o_insn_rdata(o_insn_rdata), .o_insn_err(o_insn_err),
    .i_data_req(i_data_req), .i_data_we(i_data_we),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .i_data_wsel(i_data_wsel), .o_data_ack(o_data_ack),
    .o_data_rvalid(o_data_rvalid), .o_data_rdata(o_data_rdata),
    .o_data_err(o_data_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wsel(o_mem_wsel), .i_mem_ack(i_mem_ack),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [69:0] all_outs();
    return {o_insn_ack, o_insn_rvalid, o_insn_err, o_data_ack,
            o_data_rvalid, o_data_err, o_mem_req, o_mem_we,
            o_mem_wsel, o_mem_addr[29:0]} |
           {o_insn_rdata, o_data_rdata, o_mem_wdata[5:0]} |
           {38'h0, o_mem_wdata};
  endfunction

  // Drives one request with the memory acking after a cycles and
  // returning data r cycles after the ack; observations come back out.
  task automatic do_txn(input logic isd, input logic we,
    input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wsel,
    input int a, input int r, input logic [31:0] rd,
    output logic ok_ack, output logic [69:0] fld, output int lat,
    output logic [31:0] ordata, output logic oerr, output logic oth_rv,
    output logic [31:0] oth_rd, output logic after_rv, output logic after_req);
    int cyc;
    logic stw;
    stw = isd && we;
    if (isd) begin
      i_data_req = 1; i_data_we = we; i_data_addr = addr;
      i_data_wdata = wdata; i_data_wsel = wsel;
    end else begin
      i_insn_req = 1; i_insn_addr = addr;
    end
    @(negedge i_clk);
    ok_ack = isd ? (o_data_ack && !o_insn_ack) : (o_insn_ack && !o_data_ack);
    @(posedge i_clk); #1;
    i_insn_req = 0; i_data_req = 0;
    lat = -1; cyc = 1; fld = '0; oth_rv = 0;
    ordata = '0; oerr = 0; oth_rd = '0;
    while (lat < 0 && cyc < 30) begin
      i_mem_ack = (cyc == 1 + a);
      i_mem_rvalid = (cyc < 1 + a) ? 1'($urandom % 2)
                                   : (!stw && cyc == 1 + a + r);
      i_mem_rdata = (cyc == 1 + a + r) ? rd : $urandom;
      @(negedge i_clk);
      if (cyc == 1)
        fld = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wsel};
      if (isd ? o_data_rvalid : o_insn_rvalid) begin
        lat = cyc;
        ordata = isd ? o_data_rdata : o_insn_rdata;
        oerr = isd ? o_data_err : o_insn_err;
        oth_rd = isd ? o_insn_rdata : o_data_rdata;
      end
      oth_rv |= isd ? o_insn_rvalid : o_data_rvalid;
      @(posedge i_clk); #1;
      cyc++;
    end
    i_mem_ack = 0; i_mem_rvalid = 0;
    @(negedge i_clk);
    after_rv = isd ? o_data_rvalid : o_insn_rvalid;
    after_req = o_mem_req;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_reset_n = 0;
    i_insn_req = 1; i_data_req = 1; i_insn_addr = 32'h40;
    i_data_we = 0; i_data_addr = 32'h80; i_data_wdata = 0; i_data_wsel = 0;
    i_mem_ack = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL reset_outs got %h want 0", all_outs());
    end
    @(posedge i_clk); #1;
    i_insn_req = 0; i_data_req = 0;
    i_reset_n = 1;
    @(negedge i_clk);
    tests++;
    if (all_outs() !== '0) begin
      fails++;
      $display("FAIL reset_release got %h want 0", all_outs());
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_store();
    logic ok, er, orv, arv, arq; logic [69:0] f; int lat; logic [31:0] rd, od;
    do_txn(1, 1, 32'h1000_0004, 32'hAABBCCDD, 4'b0011, 0, 0, 32'h1234,
           ok, f, lat, rd, er, orv, od, arv, arq);
    last_data = 0;
    tests += 6;
    if (ok !== 1) begin fails++; $display("FAIL store_ack got %b want 1", ok); end
    if (f !== {1'b1, 1'b1, 32'h1000_0004, 32'hAABBCCDD, 4'b0011}) begin
      fails++; $display("FAIL store_fields got %h", f);
    end
    if (lat !== 2) begin fails++; $display("FAIL store_lat got %0d want 2", lat); end
    if (rd !== 0 || er !== 0) begin
      fails++; $display("FAIL store_rsp got %h/%b want 0/0", rd, er);
    end
    if (orv !== 0) begin fails++; $display("FAIL store_other_rv got %b want 0", orv); end
    if (arv !== 0 || arq !== 0) begin
      fails++; $display("FAIL store_after got %b%b want 00", arv, arq);
    end
  endtask

  task automatic test_fetch();
    logic ok, er, orv, arv, arq; logic [69:0] f; int lat; logic [31:0] rd, od;
    do_txn(0, 0, 32'h0000_0100, 32'h0, 4'h0, 2, 3, 32'h0000_0013,
           ok, f, lat, rd, er, orv, od, arv, arq);
    last_insn = 32'h13;
    tests += 6;
    if (ok !== 1) begin fails++; $display("FAIL fetch_ack got %b want 1", ok); end
    if (f !== {1'b1, 1'b0, 32'h100, 32'h0, 4'b1111}) begin
      fails++; $display("FAIL fetch_fields got %h", f);
    end
    if (lat !== 7) begin fails++; $display("FAIL fetch_lat got %0d want 7", lat); end
    if (rd !== 32'h13 || er !== 0) begin
      fails++; $display("FAIL fetch_rsp got %h/%b want 13/0", rd, er);
    end
    if (orv !== 0) begin fails++; $display("FAIL fetch_data_rv got %b want 0", orv); end
    if (od !== last_data) begin
      fails++; $display("FAIL fetch_data_rd got %h want %h", od, last_data);
    end
  endtask

  task automatic test_random();
    logic ok, er, orv, arv, arq; logic [69:0] f, ef; int lat, elat;
    logic [31:0] rd, od, addr, wd, mrd, erd, eod;
    logic isd, we; logic [3:0] ws; int a, r;
    for (int i = 0; i < 16; i++) begin
      isd = 1'($urandom % 2); we = isd & 1'($urandom % 2);
      addr = $urandom; wd = $urandom; ws = 4'($urandom);
      a = $urandom_range(0, 3); r = $urandom_range(0, 3); mrd = $urandom;
      do_txn(isd, we, addr, wd, ws, a, r, mrd,
             ok, f, lat, rd, er, orv, od, arv, arq);
      ef = isd ? {1'b1, we, addr, wd, ws} : {1'b1, 1'b0, addr, 32'h0, 4'hF};
      elat = we ? 2 + a : 2 + a + r;
      erd = we ? 32'h0 : mrd;
      eod = isd ? last_insn : last_data;
      if (isd) last_data = erd; else last_insn = erd;
      tests += 5;
      if (ok !== 1) begin fails++; $display("FAIL rnd%0d_ack got %b want 1", i, ok); end
      if (f !== ef) begin fails++; $display("FAIL rnd%0d_fields got %h want %h", i, f, ef); end
      if (lat !== elat) begin
        fails++; $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, elat);
      end
      if (rd !== erd || er !== 0) begin
        fails++; $display("FAIL rnd%0d_rsp got %h/%b want %h/0", i, rd, er, erd);
      end
      if (orv !== 0 || od !== eod || arv !== 0) begin
        fails++; $display("FAIL rnd%0d_other got %b/%h/%b want 0/%h/0", i, orv, od, arv, eod);
      end
    end
  endtask

  task automatic test_fairness();
    string got, exp;
    int n, cyc, streak, bad;
    got = ""; exp = ""; streak = 0;
    for (int i = 0; i < 10; i++) begin
      if (streak == 4) begin exp = {exp, "I"}; streak = 0; end
      else begin exp = {exp, "D"}; streak++; end
    end
    i_insn_req = 1; i_insn_addr = 32'h200;
    i_data_req = 1; i_data_we = 0; i_data_addr = 32'h300;
    i_data_wdata = 0; i_data_wsel = 4'hF;
    n = 0; cyc = 0; bad = 0;
    while (n < 10 && cyc < 60) begin
      i_mem_ack = o_mem_req; i_mem_rvalid = o_mem_req; i_mem_rdata = $urandom;
      @(negedge i_clk);
      if (o_data_ack && o_insn_ack) bad++;
      if ((o_data_ack || o_insn_ack) && o_mem_req) bad++;
      if (o_data_ack) begin got = {got, "D"}; n++; end
      else if (o_insn_ack) begin got = {got, "I"}; n++; end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_insn_req = 0; i_data_req = 0;
    repeat (4) begin
      i_mem_ack = o_mem_req; i_mem_rvalid = o_mem_req;
      @(posedge i_clk); #1;
    end
    i_mem_ack = 0; i_mem_rvalid = 0;
    tests += 3;
    if (got != exp) begin fails++; $display("FAIL fair_order got %s want %s", got, exp); end
    if (cyc > 20) begin fails++; $display("FAIL fair_rate got %0d cycles want <=20", cyc); end
    if (bad != 0) begin fails++; $display("FAIL fair_ack got %0d bad acks want 0", bad); end
  endtask

  task automatic test_timeout();
    logic ok, er, orv, arv, arq; logic [69:0] f; int lat; logic [31:0] rd, od;
    do_txn(1, 0, 32'h2000_0000, 32'h0, 4'hF, 100, 0, 32'hDEAD,
           ok, f, lat, rd, er, orv, od, arv, arq);
    tests += 4;
    if (lat !== 9) begin fails++; $display("FAIL tmo_lat got %0d want 9", lat); end
    if (rd !== 0 || er !== 1) begin
      fails++; $display("FAIL tmo_rsp got %h/%b want 0/1", rd, er);
    end
    if (arq !== 0 || arv !== 0) begin
      fails++; $display("FAIL tmo_after got %b%b want 00", arq, arv);
    end
    do_txn(0, 0, 32'h0000_0400, 32'h0, 4'h0, 0, 0, 32'hCAFE_0001,
           ok, f, lat, rd, er, orv, od, arv, arq);
    if (ok !== 1 || lat !== 2 || rd !== 32'hCAFE_0001) begin
      fails++; $display("FAIL tmo_next got %b/%0d/%h want 1/2/cafe0001", ok, lat, rd);
    end
  endtask

  task automatic test_beats_timeout();
    logic ok, er, orv, arv, arq; logic [69:0] f; int lat; logic [31:0] rd, od;
    do_txn(1, 0, 32'h3000_0000, 32'h0, 4'hF, 2, 5, 32'h5A5A_1234,
           ok, f, lat, rd, er, orv, od, arv, arq);
    tests += 2;
    if (lat !== 9 || er !== 0 || rd !== 32'h5A5A_1234) begin
      fails++; $display("FAIL beat_load got %0d/%b/%h want 9/0/5a5a1234", lat, er, rd);
    end
    do_txn(1, 1, 32'h3000_0008, 32'h1111_2222, 4'h3, 7, 0, 32'h9,
           ok, f, lat, rd, er, orv, od, arv, arq);
    if (lat !== 9 || er !== 0 || rd !== 0) begin
      fails++; $display("FAIL beat_store got %0d/%b/%h want 9/0/0", lat, er, rd);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    i_data_req = 1; i_data_we = 0; i_data_addr = 32'h4000_0000;
    i_data_wdata = 0; i_data_wsel = 4'hF;
    @(posedge i_clk); #1;
    i_data_req = 0; i_mem_ack = 1;
    @(posedge i_clk); #1;
    i_mem_ack = 0;
    #2 i_reset_n = 0;
    #1;
    tests++;
    if (all_outs() !== '0) begin
      fails++; $display("FAIL rstmid_outs got %h want 0", all_outs());
    end
    @(posedge i_clk); #1;
    i_reset_n = 1;
    i_mem_rvalid = 1; i_mem_rdata = 32'h7777_7777;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (o_data_rvalid || o_insn_rvalid || o_mem_req || o_data_rdata != 0) bad++;
      @(posedge i_clk); #1;
      i_mem_rvalid = 0;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rstmid_late got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_fetch();
    test_random();
    test_fairness();
    test_timeout();
    test_beats_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one memory port between two requesters: the instruction-fetch port (read-only) and the data port driven from the ALU3/LSU stage (address, wdata, 4-bit wsel).
- Sequences each transaction through request, acceptance and response, and routes the response back to its owner.
- Applies data-priority arbitration with bounded instruction starvation, and a response timeout that returns an error.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in ISSUE or WAIT_RESP before an error completion; 0 disables the timeout.
- MAX_DATA_STREAK, 4: maximum consecutive data grants while an insn request is pending; range 1..15.

Ports:
- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_insn_req  in  1  fetch request; held with its address until ack
- i_insn_addr  in  32  fetch word address
- o_insn_ack  out  1  request captured (combinational, IDLE only)
- o_insn_rvalid  out  1  one-cycle pulse, fetch data valid
- o_insn_rdata  out  32  fetch data
- o_insn_err  out  1  qualifies o_insn_rvalid: timeout
- i_data_req  in  1  data request; held with its fields until ack
- i_data_we  in  1  1 = store, 0 = load
- i_data_addr  in  32  data address
- i_data_wdata  in  32  store data, already lane-replicated
- i_data_wsel  in  4  byte strobes
- o_data_ack  out  1  request captured
- o_data_rvalid  out  1  one-cycle completion pulse, loads and stores
- o_data_rdata  out  32  load data; 0 for stores
- o_data_err  out  1  qualifies o_data_rvalid: timeout
- o_mem_req  out  1  memory request, registered
- o_mem_we  out  1  registered
- o_mem_addr  out  32  registered
- o_mem_wdata  out  32  registered
- o_mem_wsel  out  4  registered; 4'b1111 for fetches
- i_mem_ack  in  1  memory accepted o_mem_req
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  read data

Behaviour:
- Clock and reset: single clock i_clk. Reset i_reset_n is asynchronous, active-low.
- State on reset: state=IDLE, owner=INSN, streak=0, timer=0.
- Outputs on reset: all registered outputs 0.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE grant rule:
  - Grant data if i_data_req && !(i_insn_req && streak==MAX_DATA_STREAK); otherwise grant insn if i_insn_req.
  - The winner's ack is asserted combinationally in that cycle.
  - On the edge: latch fields into o_mem_*, set owner, set o_mem_req=1, go to ISSUE, clear timer.
  - Fetch capture drives we=0, wsel=4'b1111, wdata=0.
- Streak counter:
  - Increments on a data grant while i_insn_req=1, saturating at MAX_DATA_STREAK.
  - Clears on an insn grant.
  - Clears on a data grant with i_insn_req=0.
- ISSUE:
  - o_mem_* held stable until i_mem_ack.
  - On ack, o_mem_req drops next cycle.
  - Store: complete on ack → owner rvalid pulse next cycle, rdata 0, go to IDLE.
  - Load/fetch with i_mem_ack only: go to WAIT_RESP.
  - Load/fetch with i_mem_ack && i_mem_rvalid in the same cycle: complete immediately.
- WAIT_RESP: on i_mem_rvalid, register i_mem_rdata into the owner's rdata, pulse the owner's rvalid next cycle, go to IDLE.
- Ignored inputs: i_mem_rvalid in IDLE, and in ISSUE without i_mem_ack, is ignored. i_mem_ack outside ISSUE is ignored.
- Timeout:
  - timer counts every cycle in ISSUE/WAIT_RESP.
  - At timer==TIMEOUT_CYCLES-1 with no completion event: owner rvalid=1, err=1, rdata=0, o_mem_req=0, go to IDLE.
  - A completion event in the same cycle wins over the timeout.
- Pulse widths: rvalid and err are exactly one cycle. The non-owner's rvalid/rdata stay 0.
- rdata persistence: the owner's rdata holds its value after the pulse until the next completion for that owner.
- Throughput: min 3 cycles per zero-wait read (IDLE grant, ISSUE with ack+rvalid, response cycle that is also IDLE). The next grant may occur in the response cycle.
- One transaction outstanding at most. No ack is issued outside IDLE.
- Reset mid-transaction: transaction dropped, no response pulse, outputs to reset values.

Test Plan:
- Store path:
  - Stimulus: data req only, we=1, addr=0x1000_0004, wdata=0xAABBCCDD, wsel=4'b0011; memory acks in first ISSUE cycle.
  - Required: o_data_ack in cycle 0; o_mem_req=1 in cycle 1 with fields exact; o_data_rvalid=1 in cycle 2 with rdata=0, err=0.
- Fetch path:
  - Stimulus: fetch with 2-cycle ack delay and rvalid 3 cycles after ack, rdata=0x00000013.
  - Required: o_mem_wsel=4'b1111; o_insn_rvalid one cycle after i_mem_rvalid, rdata=0x13; o_data_rvalid stays 0.
- Arbitration fairness:
  - Stimulus: both reqs held continuously, MAX_DATA_STREAK=4, zero-wait memory.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; streak clears after each I.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, memory never acks a load.
  - Required: o_data_rvalid=1 with err=1, rdata=0, 8 cycles after entering ISSUE; o_mem_req low next; IDLE grants a new request.
- Completion beats timeout: i_mem_rvalid arrives exactly at the timeout cycle → normal completion, err=0, correct data.
- Reset mid-read: assert i_reset_n=0 asynchronously in WAIT_RESP → all outputs 0 immediately; no rvalid after release; a late i_mem_rvalid is ignored.
